alu_seq: RTL and testbench

Multi-byte arithmetic/logic sequencer that drives the 8-bit `alu` one byte per cycle. It chains carry/borrow between bytes and accumulates flags, producing BYTES-wide results. It sits between the CPU control path and the ALU, and is the initiator for the ALU's operand/op/carry interface. This lets the micro execute 16/32-bit ADD/SUB and bitwise ops without widening the datapath.

---
 rtl/cpu_pkg.sv | 23 ++
 rtl/alu.sv | 46 ++++
 rtl/alu_seq.sv | 140 ++++++++++++++
 tb/tb_alu_seq.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU types.
//   Operation   : ALU operation selector (ADD, SUB and four bitwise ops).
//   seq_state_e : state encoding for the multi-byte ALU sequencer.
//   BYTE_W      : width of one ALU byte lane, used for operand slicing.
package cpu_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    ADD  = 3'd0,
    SUB  = 3'd1,
    NOR  = 3'd2,
    NAND = 3'd3,
    XOR  = 3'd4,
    XNOR = 3'd5
  } Operation;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } seq_state_e;

endpackage

// File: rtl/alu.sv
// 8-bit combinational ALU.
//   _iOp        : operation select
//   _iA, _iB    : byte operands
//   _iC         : carry (ADD) or borrow (SUB) in; ignored for logic ops
//   _oResult    : byte result
//   _oFlagCarry : carry out (ADD), borrow out (SUB), 0 for logic ops
//   _oFlagZero  : result byte is zero
module alu
  import cpu_pkg::*;
(
  input  Operation             _iOp,
  input  logic [BYTE_W-1:0]    _iA,
  input  logic [BYTE_W-1:0]    _iB,
  input  logic                 _iC,
  output logic [BYTE_W-1:0]    _oResult,
  output logic                 _oFlagCarry,
  output logic                 _oFlagZero
);

  logic [BYTE_W:0] wide;

  always_comb begin
    wide        = '0;
    _oFlagCarry = 1'b0;
    unique case (_iOp)
      ADD: begin
        wide        = {1'b0, _iA} + {1'b0, _iB} + {{BYTE_W{1'b0}}, _iC};
        _oFlagCarry = wide[BYTE_W];
      end
      SUB: begin
        // A 9-bit difference that goes negative sets its top bit: that is the borrow.
        wide        = {1'b0, _iA} - {1'b0, _iB} - {{BYTE_W{1'b0}}, _iC};
        _oFlagCarry = wide[BYTE_W];
      end
      NOR:     wide = {1'b0, ~(_iA | _iB)};
      NAND:    wide = {1'b0, ~(_iA & _iB)};
      XOR:     wide = {1'b0, _iA ^ _iB};
      XNOR:    wide = {1'b0, ~(_iA ^ _iB)};
      default: wide = '0;
    endcase
  end

  assign _oResult  = wide[BYTE_W-1:0];
  assign _oFlagZero = (wide[BYTE_W-1:0] == '0);

endmodule

// File: rtl/alu_seq.sv
// Multi-byte ALU sequencer: feeds one byte per cycle through a single 8-bit
// alu, chaining carry/borrow between bytes and accumulating the zero flag.
//   clk, reset_n      : clock, asynchronous active-low reset
//   _iStart           : request, sampled only while idle
//   _iOp, _iA, _iB    : operation and BYTES-wide operands, latched at start
//   _iCarryIn         : carry/borrow into byte 0, latched at start
//   _oBusy            : operation in progress
//   _oDone            : one-cycle pulse when result and flags are valid
//   _oResult          : BYTES-wide result (partial while busy)
//   _oFlagCarry       : carry/borrow out of the top byte, 0 for logic ops
//   _oFlagZero        : all result bytes zero
//   _oFlagNeg         : top bit of the result
module alu_seq
  import cpu_pkg::*;
#(
  parameter int BYTES = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      _iStart,
  input  Operation                  _iOp,
  input  logic [BYTE_W*BYTES-1:0]   _iA,
  input  logic [BYTE_W*BYTES-1:0]   _iB,
  input  logic                      _iCarryIn,
  output logic                      _oBusy,
  output logic                      _oDone,
  output logic [BYTE_W*BYTES-1:0]   _oResult,
  output logic                      _oFlagCarry,
  output logic                      _oFlagZero,
  output logic                      _oFlagNeg
);

  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

  seq_state_e                      state_q, state_d;
  logic [IDX_W-1:0]                idx_q, idx_d;
  Operation                        op_q, op_d;
  logic [BYTES-1:0][BYTE_W-1:0]    a_q, a_d;
  logic [BYTES-1:0][BYTE_W-1:0]    b_q, b_d;
  logic                            cin_q, cin_d;
  logic                            carry_q, carry_d;
  logic                            zero_q, zero_d;
  logic [BYTES-1:0][BYTE_W-1:0]    result_q, result_d;
  logic                            done_q, done_d;

  logic [BYTE_W-1:0]               alu_res;
  logic                            alu_c_in;
  logic                            alu_carry;
  logic                            alu_zero;

  // Byte 0 takes the latched carry-in; later bytes chain the previous byte's carry.
  assign alu_c_in = (idx_q == '0) ? cin_q : carry_q;

  alu u_alu (
    ._iOp        (op_q),
    ._iA         (a_q[idx_q]),
    ._iB         (b_q[idx_q]),
    ._iC         (alu_c_in),
    ._oResult    (alu_res),
    ._oFlagCarry (alu_carry),
    ._oFlagZero  (alu_zero)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    cin_d    = cin_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    result_d = result_q;
    done_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (_iStart) begin
          state_d  = S_RUN;
          op_d     = _iOp;
          a_d      = _iA;
          b_d      = _iB;
          cin_d    = _iCarryIn;
          idx_d    = '0;
          carry_d  = 1'b0;
          // The zero accumulator is an AND chain, so it starts at 1.
          zero_d   = 1'b1;
          result_d = '0;
        end
      end
      S_RUN: begin
        result_d[idx_q] = alu_res;
        carry_d         = alu_carry;
        zero_d          = zero_q & alu_zero;
        if (idx_q == LAST_IDX) begin
          state_d = S_IDLE;
          idx_d   = '0;
          done_d  = 1'b1;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      op_q     <= ADD;
      a_q      <= '0;
      b_q      <= '0;
      cin_q    <= 1'b0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cin_q    <= cin_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign _oBusy      = (state_q == S_RUN);
  assign _oDone      = done_q;
  assign _oResult    = result_q;
  assign _oFlagCarry = carry_q;
  assign _oFlagZero  = zero_q;
  assign _oFlagNeg   = result_q[BYTES-1][BYTE_W-1];

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: a 2-byte and a 4-byte instance checked against a
// full-width integer model, plus directed control scenarios on the 4-byte one.
module tb_alu_seq;
  import cpu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;

  logic        st2, st4;
  Operation    op2, op4;
  logic [15:0] a2, b2;
  logic [31:0] a4, b4;
  logic        ci2, ci4;

  logic        bz2, dn2, c2, z2, n2;
  logic        bz4, dn4, c4, z4, n4;
  logic [15:0] r2;
  logic [31:0] r4;

  int checks = 0;
  int errors = 0;

  alu_seq #(.BYTES(2)) dut2 (
    .clk(clk), .reset_n(reset_n), ._iStart(st2), ._iOp(op2), ._iA(a2), ._iB(b2),
    ._iCarryIn(ci2), ._oBusy(bz2), ._oDone(dn2), ._oResult(r2),
    ._oFlagCarry(c2), ._oFlagZero(z2), ._oFlagNeg(n2)
  );

  alu_seq #(.BYTES(4)) dut4 (
    .clk(clk), .reset_n(reset_n), ._iStart(st4), ._iOp(op4), ._iA(a4), ._iB(b4),
    ._iCarryIn(ci4), ._oBusy(bz4), ._oDone(dn4), ._oResult(r4),
    ._oFlagCarry(c4), ._oFlagZero(z4), ._oFlagNeg(n4)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Full-width reference: returns {carry, result}.
  function automatic logic [64:0] model(input Operation op, input logic [63:0] a,
                                        input logic [63:0] b, input logic cin,
                                        input int nb);
    logic [64:0] mask;
    logic [64:0] full;
    logic        c;
    mask = (65'd1 << (8 * nb)) - 65'd1;
    c    = 1'b0;
    case (op)
      ADD: begin
        full = {1'b0, a} + {1'b0, b} + 65'(cin);
        c    = (full > mask);
      end
      SUB: begin
        full = {1'b0, a} - {1'b0, b} - 65'(cin);
        c    = full[64];
      end
      NOR:     full = ~({1'b0, a} | {1'b0, b});
      NAND:    full = ~({1'b0, a} & {1'b0, b});
      XOR:     full = {1'b0, a} ^ {1'b0, b};
      default: full = ~({1'b0, a} ^ {1'b0, b});
    endcase
    full = full & mask;
    return {c, full[63:0]};
  endfunction

  function automatic logic busy_of(input int u);
    return (u == 0) ? bz2 : bz4;
  endfunction

  function automatic logic done_of(input int u);
    return (u == 0) ? dn2 : dn4;
  endfunction

  // Called #1 after an edge; returns #1 after the edge that raised done.
  task automatic run_op(input int u, input Operation op, input logic [63:0] a_in,
                        input logic [63:0] b_in, input logic cin,
                        output logic [63:0] res, output logic carry, output logic zero);
    int          nb;
    int          cnt;
    logic [63:0] a, b, mask;
    logic [64:0] m;
    logic        neg;
    nb   = (u == 0) ? 2 : 4;
    mask = (nb == 2) ? 64'hFFFF : 64'hFFFF_FFFF;
    a    = a_in & mask;
    b    = b_in & mask;
    m    = model(op, a, b, cin, nb);
    if (u == 0) begin
      st2 = 1'b1; op2 = op; a2 = a[15:0]; b2 = b[15:0]; ci2 = cin;
    end else begin
      st4 = 1'b1; op4 = op; a4 = a[31:0]; b4 = b[31:0]; ci4 = cin;
    end
    @(posedge clk); #1;
    if (u == 0) st2 = 1'b0; else st4 = 1'b0;
    check("busy after start", 64'(busy_of(u)), 64'd1);
    check("done low after start", 64'(done_of(u)), 64'd0);
    cnt = 0;
    while (!done_of(u) && cnt < nb + 3) begin
      @(posedge clk); #1;
      cnt++;
    end
    check("start-to-done edges", 64'(cnt), 64'(nb));
    check("busy low with done", 64'(busy_of(u)), 64'd0);
    if (u == 0) begin
      res = 64'(r2); carry = c2; zero = z2; neg = n2;
    end else begin
      res = 64'(r4); carry = c4; zero = z4; neg = n4;
    end
    check("result", res, m[63:0]);
    check("carry", 64'(carry), 64'(m[64]));
    check("zero", 64'(zero), 64'(m[63:0] == 64'd0));
    check("neg", 64'(neg), 64'(m[8*nb-1]));
  endtask

  function automatic logic [63:0] rand_operand(input logic [63:0] mask);
    int unsigned pick;
    pick = $urandom_range(0, 7);
    if (pick == 0) return 64'd0;
    if (pick == 1) return mask;
    return {$urandom, $urandom} & mask;
  endfunction

  task automatic rand_loop(input int u, input int n);
    logic [63:0] mask, r;
    logic        c, z;
    mask = (u == 0) ? 64'hFFFF : 64'hFFFF_FFFF;
    for (int i = 0; i < n; i++) begin
      run_op(u, Operation'($urandom_range(0, 5)), rand_operand(mask), rand_operand(mask),
             1'($urandom_range(0, 1)), r, c, z);
    end
  endtask

  initial begin : main
    logic [63:0] r;
    logic        c, z;
    int          cnt;
    st2 = 0; op2 = ADD; a2 = '0; b2 = '0; ci2 = 0;
    st4 = 0; op4 = ADD; a4 = '0; b4 = '0; ci4 = 0;
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", 64'(bz4), 64'd0);
    check("reset done", 64'(dn4), 64'd0);
    check("reset result", 64'(r4), 64'd0);
    check("reset flags", {61'd0, c4, z4, n4}, 64'd0);
    check("reset busy2", 64'(bz2), 64'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    run_op(1, ADD, 64'hFFFF_FFFF, 64'h0, 1'b1, r, c, z);
    check("add wrap result", r, 64'h0);
    check("add wrap carry", 64'(c), 64'd1);
    check("add wrap zero", 64'(z), 64'd1);
    check("add wrap neg", 64'(n4), 64'd0);

    // Next start lands in the done cycle of the previous one.
    run_op(1, SUB, 64'h0, 64'h1, 1'b0, r, c, z);
    check("sub borrow result", r, 64'hFFFF_FFFF);
    check("sub borrow carry", 64'(c), 64'd1);
    check("sub borrow neg", 64'(n4), 64'd1);
    check("sub borrow zero", 64'(z), 64'd0);

    run_op(1, ADD, 64'h100, 64'h0, 1'b0, r, c, z);
    check("upper byte result", r, 64'h100);
    check("upper byte zero", 64'(z), 64'd0);

    run_op(1, XOR, 64'hA5A5_A5A5, 64'hFFFF_0000, 1'b1, r, c, z);
    check("xor result", r, 64'h5A5A_A5A5);
    check("xor carry", 64'(c), 64'd0);

    // A second start two cycles into a run must be dropped.
    @(posedge clk); #1;
    st4 = 1'b1; op4 = ADD; a4 = 32'h1; b4 = 32'h2; ci4 = 1'b0;
    @(posedge clk); #1;
    st4 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    st4 = 1'b1; op4 = SUB; a4 = 32'h55; b4 = 32'h77; ci4 = 1'b1;
    @(posedge clk); #1;
    st4 = 1'b0;
    cnt = 3;
    while (!dn4 && cnt < 10) begin
      @(posedge clk); #1;
      cnt++;
    end
    check("ignored start latency", 64'(cnt), 64'd4);
    check("ignored start result", 64'(r4), 64'h3);
    @(posedge clk); #1;
    check("no queued op busy", 64'(bz4), 64'd0);
    check("no queued op done", 64'(dn4), 64'd0);

    // Reset in the middle of a run aborts it.
    st4 = 1'b1; op4 = ADD; a4 = 32'h1234_5678; b4 = 32'h1111_1111; ci4 = 1'b0;
    @(posedge clk); #1;
    st4 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    check("abort busy", 64'(bz4), 64'd0);
    check("abort outputs", {r4, c4, z4, n4, dn4}, 64'd0);
    cnt = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (dn4) cnt++;
    end
    check("abort no done", 64'(cnt), 64'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    run_op(1, ADD, 64'h1234_5678, 64'h1111_1111, 1'b1, r, c, z);
    check("after abort result", r, 64'h2345_678A);

    fork
      rand_loop(0, 10000);
      rand_loop(1, 10000);
    join

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
